// File: rtl/cpu_isa_pkg.sv
// ----------------------------------------------------------------------------
// cpu_isa_pkg
//   Shared ISA definitions for the fetch path: opcodes that carry a second
//   (immediate/target) word, the fetch FSM state type, and a helper that
//   classifies an opcode as one- or two-word.
// ----------------------------------------------------------------------------
package cpu_isa_pkg;

  localparam logic [5:0] OPC_LDI = 6'h0D;
  localparam logic [5:0] OPC_JEQ = 6'h10;
  localparam logic [5:0] OPC_JNE = 6'h11;
  localparam logic [5:0] OPC_JMP = 6'h12;

  // HALT is only reachable when the halt-detect feature is compiled in.
  typedef enum logic [1:0] {
    F_OP  = 2'd0,
    F_IMM = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  function automatic logic is_two_word(input logic [5:0] opcode);
    return (opcode == OPC_LDI) || (opcode == OPC_JEQ) ||
           (opcode == OPC_JNE) || (opcode == OPC_JMP);
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage. Owns the program counter, drives the ROM address
//   directly from it, assembles one- or two-word instructions and offers them
//   to the decoder over a valid/ready handshake. Execute can redirect the PC
//   at any time; a redirect discards any partially fetched instruction.
//
// Ports
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset (dominates redirect)
//   rom_addr       ROM word address (the PC register)
//   rom_data       ROM word at rom_addr, combinational read
//   out_valid      instruction bundle valid
//   out_ready      decoder accepts bundle
//   out_instr      opcode word
//   out_imm        second word, 0 for one-word instructions
//   out_two_word   bundle carries an immediate
//   out_pc         address of the opcode word
//   redirect_valid taken branch / jump from execute
//   redirect_pc    new fetch address
//   halted         self-loop detected (0 unless halt detect is built in)
//
// Build option
//   FETCH_HALT_DETECT_EN : when defined, accepting a JMP whose target is its
//   own address parks the unit in HALT (PC frozen, no bundles) until a
//   redirect or reset.
// ----------------------------------------------------------------------------
module fetch_unit
  import cpu_isa_pkg::*;
#(
  parameter int              ADDR_W   = 16,
  parameter int              DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0001
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [DATA_W-1:0] out_imm,
  output logic              out_two_word,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted
);

  fetch_state_t      r_state, w_state;
  logic [ADDR_W-1:0] r_pc, w_pc;
  logic              r_valid, w_valid;
  logic [DATA_W-1:0] r_instr, w_instr;
  logic [DATA_W-1:0] r_imm, w_imm;
  logic              r_two_word, w_two_word;
  logic [ADDR_W-1:0] r_out_pc, w_out_pc;
  logic [ADDR_W-1:0] w_pc_inc;
`ifdef FETCH_HALT_DETECT_EN
  logic              r_halted, w_halted;
  logic              w_self_loop;
`endif

  // PC wraps modulo 2^ADDR_W, so an immediate after 0xFFFF is read from 0.
  assign w_pc_inc = r_pc + ADDR_W'(1);

`ifdef FETCH_HALT_DETECT_EN
  assign w_self_loop = (r_instr[5:0] == OPC_JMP) && (ADDR_W'(r_imm) == r_out_pc);
`endif

  always_comb begin
    w_state    = r_state;
    w_pc       = r_pc;
    w_valid    = r_valid;
    w_instr    = r_instr;
    w_imm      = r_imm;
    w_two_word = r_two_word;
    w_out_pc   = r_out_pc;
`ifdef FETCH_HALT_DETECT_EN
    w_halted   = r_halted;
`endif

    case (r_state)
      F_OP: begin
        w_instr  = rom_data;
        w_out_pc = r_pc;
        w_pc     = w_pc_inc;
        if (is_two_word(rom_data[5:0])) begin
          w_two_word = 1'b1;
          w_state    = F_IMM;
        end else begin
          w_two_word = 1'b0;
          w_imm      = '0;
          w_valid    = 1'b1;
          w_state    = HOLD;
        end
      end
      F_IMM: begin
        w_imm   = rom_data;
        w_pc    = w_pc_inc;
        w_valid = 1'b1;
        w_state = HOLD;
      end
      HOLD: begin
        if (r_valid && out_ready) begin
          w_valid = 1'b0;
          w_state = F_OP;
`ifdef FETCH_HALT_DETECT_EN
          if (w_self_loop) begin
            w_halted = 1'b1;
            w_state  = HALT;
          end
`endif
        end
      end
`ifdef FETCH_HALT_DETECT_EN
      HALT: ;  // parked: PC and outputs frozen until redirect/reset
`endif
      default: w_state = F_OP;
    endcase

    // Redirect overrides every transition; a same-cycle handshake is void.
    if (redirect_valid) begin
      w_pc    = redirect_pc;
      w_valid = 1'b0;
      w_state = F_OP;
`ifdef FETCH_HALT_DETECT_EN
      w_halted = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= F_OP;
      r_pc       <= RESET_PC;
      r_valid    <= 1'b0;
      r_instr    <= '0;
      r_imm      <= '0;
      r_two_word <= 1'b0;
      r_out_pc   <= '0;
`ifdef FETCH_HALT_DETECT_EN
      r_halted   <= 1'b0;
`endif
    end else begin
      r_state    <= w_state;
      r_pc       <= w_pc;
      r_valid    <= w_valid;
      r_instr    <= w_instr;
      r_imm      <= w_imm;
      r_two_word <= w_two_word;
      r_out_pc   <= w_out_pc;
`ifdef FETCH_HALT_DETECT_EN
      r_halted   <= w_halted;
`endif
    end
  end

  assign rom_addr     = r_pc;
  assign out_valid    = r_valid;
  assign out_instr    = r_instr;
  assign out_imm      = r_imm;
  assign out_two_word = r_two_word;
  assign out_pc       = r_out_pc;
`ifdef FETCH_HALT_DETECT_EN
  assign halted       = r_halted;
`else
  assign halted       = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit
//   Bench for fetch_unit: directed scenarios with literal expectations, then a
//   randomized run compared every cycle against a transaction-level model of
//   the fetch stage (PC, pending-immediate flag, offered bundle).
// ----------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] rom_addr;
  logic [15:0] rom_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_imm;
  logic        out_two_word;
  logic [15:0] out_pc;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halted;

  logic [15:0] rom [0:65535];
  assign rom_data = rom[rom_addr];

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'h0001)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_imm        (out_imm),
    .out_two_word   (out_two_word),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
  );

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit carries_imm(input logic [15:0] w);
    return (w[5:0] == 6'h0D) || (w[5:0] == 6'h10) || (w[5:0] == 6'h11) || (w[5:0] == 6'h12);
  endfunction

  logic [15:0] m_pc;
  bit          m_valid, m_need_imm, m_two, m_halted;
  logic [15:0] m_instr, m_imm, m_opc_pc;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pc <= 16'h0001; m_valid <= 0; m_need_imm <= 0; m_two <= 0; m_halted <= 0;
      m_instr <= 0; m_imm <= 0; m_opc_pc <= 0;
    end else if (redirect_valid) begin
      m_pc <= redirect_pc; m_valid <= 0; m_need_imm <= 0; m_halted <= 0;
    end else if (m_halted) begin
      // parked
    end else if (m_valid) begin
      if (out_ready) begin
        m_valid <= 0;
`ifdef FETCH_HALT_DETECT_EN
        if (m_instr[5:0] == 6'h12 && m_imm == m_opc_pc) m_halted <= 1;
`endif
      end
    end else if (m_need_imm) begin
      m_imm <= rom[m_pc]; m_pc <= m_pc + 16'd1; m_valid <= 1; m_need_imm <= 0;
    end else begin
      m_instr <= rom[m_pc]; m_opc_pc <= m_pc; m_pc <= m_pc + 16'd1;
      m_two <= carries_imm(rom[m_pc]);
      if (carries_imm(rom[m_pc])) m_need_imm <= 1;
      else begin m_imm <= 0; m_valid <= 1; end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rom_addr", {16'h0, rom_addr}, {16'h0, m_pc});
      chk("out_valid", {31'h0, out_valid}, {31'h0, m_valid});
      chk("halted", {31'h0, halted}, {31'h0, m_halted});
      if (m_valid) begin
        chk("out_instr", {16'h0, out_instr}, {16'h0, m_instr});
        chk("out_imm", {16'h0, out_imm}, {16'h0, m_imm});
        chk("out_pc", {16'h0, out_pc}, {16'h0, m_opc_pc});
        chk("out_two_word", {31'h0, out_two_word}, {31'h0, m_two});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic bundle(input string tag, input logic [15:0] ins, input logic [15:0] imm,
                        input logic [15:0] pc, input logic two);
    chk({tag, "_valid"}, {31'h0, out_valid}, 32'h1);
    chk({tag, "_instr"}, {16'h0, out_instr}, {16'h0, ins});
    chk({tag, "_imm"}, {16'h0, out_imm}, {16'h0, imm});
    chk({tag, "_pc"}, {16'h0, out_pc}, {16'h0, pc});
    chk({tag, "_two"}, {31'h0, out_two_word}, {31'h0, two});
  endtask

  logic [5:0]  two_ops [4] = '{6'h0D, 6'h10, 6'h11, 6'h12};
  logic [15:0] loop_addr [8];

  initial begin
    rst_n = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 16'h0;
    for (int i = 0; i < 65536; i++) rom[i] = 16'h0000;
    rom[16'h0001] = 16'h008D; rom[16'h0002] = 16'h0004; rom[16'h0003] = 16'hE08E;
    rom[16'h0004] = 16'h0001; rom[16'h0005] = 16'h0010; rom[16'h0006] = 16'hAAAA;
    rom[16'h0010] = 16'h0003; rom[16'hFFFF] = 16'h008D; rom[16'h0000] = 16'h1234;
    rom[16'h0077] = 16'h0092; rom[16'h0078] = 16'h0077;

    @(posedge clk); @(negedge clk);
    chk_en = 1'b1;
    chk("rst_rom_addr", {16'h0, rom_addr}, 32'h0001);
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_instr", {16'h0, out_instr}, 32'h0);
    chk("rst_imm", {16'h0, out_imm}, 32'h0);
    chk("rst_pc", {16'h0, out_pc}, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);

    // two-word LDI then one-word instruction
    rst_n = 1'b1;
    step(); chk("t1_fetch_addr", {16'h0, rom_addr}, 32'h0002);
    chk("t1_not_yet_valid", {31'h0, out_valid}, 32'h0);
    step(); bundle("t1", 16'h008D, 16'h0004, 16'h0001, 1'b1);
    step(); chk("t2_hs_valid", {31'h0, out_valid}, 32'h0);
    step(); bundle("t2", 16'hE08E, 16'h0000, 16'h0003, 1'b0);
    chk("t2_next_addr", {16'h0, rom_addr}, 32'h0004);

    // back-pressure holds the bundle and the PC
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(); bundle("t3_hold", 16'hE08E, 16'h0000, 16'h0003, 1'b0);
      chk("t3_hold_addr", {16'h0, rom_addr}, 32'h0004);
    end
    out_ready = 1'b1;
    step(); chk("t3_after_hs", {31'h0, out_valid}, 32'h0);
    chk("t3_addr_after_hs", {16'h0, rom_addr}, 32'h0004);
    step(); bundle("t3_next", 16'h0001, 16'h0000, 16'h0004, 1'b0);

    // redirect during the immediate fetch drops the partial bundle
    step(); step();
    chk("t4_in_imm_addr", {16'h0, rom_addr}, 32'h0006);
    redirect_valid = 1'b1; redirect_pc = 16'h0010;
    step(); redirect_valid = 1'b0;
    chk("t4_redir_addr", {16'h0, rom_addr}, 32'h0010);
    chk("t4_redir_valid", {31'h0, out_valid}, 32'h0);
    step(); bundle("t4_new", 16'h0003, 16'h0000, 16'h0010, 1'b0);

    // redirect with a simultaneous handshake, then fetch across the wrap
    redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
    step(); redirect_valid = 1'b0;
    chk("t5_addr", {16'h0, rom_addr}, 32'hFFFF);
    chk("t5_valid", {31'h0, out_valid}, 32'h0);
    step(); chk("t5_wrap_addr", {16'h0, rom_addr}, 32'h0000);
    step(); bundle("t5", 16'h008D, 16'h1234, 16'hFFFF, 1'b1);
    chk("t5_after_addr", {16'h0, rom_addr}, 32'h0001);

    // self-loop JMP at 0x77
    step();
    redirect_valid = 1'b1; redirect_pc = 16'h0077;
    step(); redirect_valid = 1'b0;
    step(); step(); bundle("t6", 16'h0092, 16'h0077, 16'h0077, 1'b1);
    step();
`ifdef FETCH_HALT_DETECT_EN
    chk("t6_halted", {31'h0, halted}, 32'h1);
    chk("t6_halt_valid", {31'h0, out_valid}, 32'h0);
    step(3);
    chk("t6_frozen_addr", {16'h0, rom_addr}, 32'h0079);
    chk("t6_still_halted", {31'h0, halted}, 32'h1);
`else
    chk("t6_no_halt", {31'h0, halted}, 32'h0);
`endif
    redirect_valid = 1'b1; redirect_pc = 16'h0001;
    step(); redirect_valid = 1'b0;
    chk("t6_resume_halted", {31'h0, halted}, 32'h0);
    chk("t6_resume_addr", {16'h0, rom_addr}, 32'h0001);

    // reset mid-instruction, asserted together with a redirect
    step();
    rst_n = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'h0100;
    step(); rst_n = 1'b1; redirect_valid = 1'b0;
    chk("t7_rst_addr", {16'h0, rom_addr}, 32'h0001);
    chk("t7_rst_valid", {31'h0, out_valid}, 32'h0);
    chk("t7_rst_two", {31'h0, out_two_word}, 32'h0);

    // randomized run
    for (int i = 0; i < 65536; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if ($urandom_range(0, 2) == 0) w[5:0] = two_ops[$urandom_range(0, 3)];
      rom[i] = w;
    end
    for (int k = 0; k < 7; k++) begin
      loop_addr[k] = 16'($urandom_range(2, 16'hFFF0));
      rom[loop_addr[k]] = 16'h0092;
      rom[loop_addr[k] + 16'd1] = loop_addr[k];
    end
    loop_addr[7] = 16'hFFFF; rom[16'hFFFF] = 16'h0092; rom[16'h0000] = 16'hFFFF;

    for (int c = 0; c < 4000; c++) begin
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 3))
        0: redirect_pc = loop_addr[$urandom_range(0, 7)];
        1: redirect_pc = 16'hFFFE + 16'($urandom_range(0, 1));
        default: redirect_pc = 16'($urandom);
      endcase
      rst_n = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
